// File: rtl/wb_pkg.sv
// Shared types for the writeback queue: field widths and the queued write request.
package wb_pkg;

    localparam int unsigned REG_W  = 5;
    localparam int unsigned DATA_W = 32;

    typedef struct packed {
        logic              live;
        logic [REG_W-1:0]  wreg;
        logic [DATA_W-1:0] wdata;
    } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of writeback requests with in-place squash of matching entries.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  wb_req_t                      push_data,
    input  logic                         pop,
    input  logic                         squash_en,
    input  logic [REG_W-1:0]             squash_reg,
    output wb_req_t [DEPTH-1:0]          entries,
    output logic    [DEPTH-1:0]          occ,
    output logic    [$clog2(DEPTH)-1:0]  head_idx,
    output logic    [$clog2(DEPTH):0]    count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    wb_req_t [DEPTH-1:0] mem;
    logic    [PTR_W-1:0] wr_ptr;
    logic    [PTR_W-1:0] rd_ptr;
    logic    [CNT_W-1:0] cnt;
    wb_req_t             push_entry;

    // An entry pushed in the same cycle as a matching primary write arrives already dead.
    always_comb begin
        push_entry = push_data;
        if (squash_en && (push_data.wreg == squash_reg)) begin
            push_entry.live = 1'b0;
        end
    end

    // A slot is occupied when its distance from the read pointer is below the count.
    always_comb begin
        occ = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            occ[i] = CNT_W'(PTR_W'(PTR_W'(i) - rd_ptr)) < cnt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (squash_en) begin
                for (int i = 0; i < int'(DEPTH); i++) begin
                    if (mem[i].wreg == squash_reg) begin
                        mem[i].live <= 1'b0;
                    end
                end
            end
            if (push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            cnt <= cnt + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign entries  = mem;
    assign head_idx = rd_ptr;
    assign count    = cnt;

endmodule

// File: rtl/wb_queue.sv
// Writeback arbiter: primary pipeline has priority, multi-cycle results queue behind it.
module wb_queue
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     p_valid,
    input  logic [REG_W-1:0]         p_wreg,
    input  logic [DATA_W-1:0]        p_wdata,
    input  logic                     m_valid,
    output logic                     m_ready,
    input  logic [REG_W-1:0]         m_wreg,
    input  logic [DATA_W-1:0]        m_wdata,
    output logic                     we,
    output logic [REG_W-1:0]         wreg,
    output logic [DATA_W-1:0]        wdata,
    input  logic [REG_W-1:0]         chk_reg1,
    input  logic [REG_W-1:0]         chk_reg2,
    output logic                     busy1,
    output logic                     busy2,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    wb_req_t [DEPTH-1:0] entries;
    logic    [DEPTH-1:0] occ;
    logic    [PTR_W-1:0] head_idx;
    wb_req_t             head;
    wb_req_t             push_data;
    logic                p_acc;
    logic                push_fire;
    logic                store;
    logic                pop;

    assign p_acc     = p_valid && (p_wreg != '0);
    assign m_ready   = rst_n && (count < CNT_W'(DEPTH));
    assign push_fire = m_valid && m_ready;
    // Writes to r0 are handshaken but never occupy a slot.
    assign store     = push_fire && (m_wreg != '0);
    assign pop       = !p_acc && (count != '0);
    assign head      = entries[head_idx];

    always_comb begin
        push_data       = '0;
        push_data.live  = 1'b1;
        push_data.wreg  = m_wreg;
        push_data.wdata = m_wdata;
    end

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (store),
        .push_data  (push_data),
        .pop        (pop),
        .squash_en  (p_acc),
        .squash_reg (p_wreg),
        .entries    (entries),
        .occ        (occ),
        .head_idx   (head_idx),
        .count      (count)
    );

    // Output stage feeding the register-file write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we    <= 1'b0;
            wreg  <= '0;
            wdata <= '0;
        end else if (p_acc) begin
            we    <= 1'b1;
            wreg  <= p_wreg;
            wdata <= p_wdata;
        end else if (pop) begin
            we    <= head.live;
            wreg  <= head.wreg;
            wdata <= head.wdata;
        end else begin
            we    <= 1'b0;
        end
    end

    // Pending-write lookup over live queued entries plus the output stage.
    always_comb begin
        busy1 = 1'b0;
        busy2 = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (occ[i] && entries[i].live) begin
                if (entries[i].wreg == chk_reg1) busy1 = 1'b1;
                if (entries[i].wreg == chk_reg2) busy2 = 1'b1;
            end
        end
        if (we && (wreg == chk_reg1)) busy1 = 1'b1;
        if (we && (wreg == chk_reg2)) busy2 = 1'b1;
        if (chk_reg1 == '0) busy1 = 1'b0;
        if (chk_reg2 == '0) busy2 = 1'b0;
    end

endmodule

// File: tb/tb_wb_queue.sv
// Directed bench for wb_queue with hand-computed expectations.
module tb_wb_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        p_valid;
    logic [4:0]  p_wreg;
    logic [31:0] p_wdata;
    logic        m_valid;
    logic        m_ready;
    logic [4:0]  m_wreg;
    logic [31:0] m_wdata;
    logic        we;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic [4:0]  chk_reg1;
    logic [4:0]  chk_reg2;
    logic        busy1;
    logic        busy2;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    wb_queue #(.DEPTH(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .p_valid  (p_valid),
        .p_wreg   (p_wreg),
        .p_wdata  (p_wdata),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_wreg   (m_wreg),
        .m_wdata  (m_wdata),
        .we       (we),
        .wreg     (wreg),
        .wdata    (wdata),
        .chk_reg1 (chk_reg1),
        .chk_reg2 (chk_reg2),
        .busy1    (busy1),
        .busy2    (busy2),
        .count    (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        p_valid = 1'b0;
        m_valid = 1'b0;
    endtask

    task automatic prim(input logic [4:0] r, input logic [31:0] d);
        p_valid = 1'b1;
        p_wreg  = r;
        p_wdata = d;
    endtask

    task automatic mpush(input logic [4:0] r, input logic [31:0] d);
        m_valid = 1'b1;
        m_wreg  = r;
        m_wdata = d;
    endtask

    initial begin
        rst_n = 1'b0;
        p_valid = 1'b0; p_wreg = '0; p_wdata = '0;
        m_valid = 1'b0; m_wreg = '0; m_wdata = '0;
        chk_reg1 = 5'd8; chk_reg2 = 5'd0;
        #1;
        check("rst_m_ready", 64'(m_ready), 64'd0);
        check("rst_we", 64'(we), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        check("idle_we", 64'(we), 64'd0);
        check("idle_wreg", 64'(wreg), 64'd0);
        check("idle_wdata", 64'(wdata), 64'd0);
        check("idle_m_ready", 64'(m_ready), 64'd1);
        check("idle_count", 64'(count), 64'd0);
        check("idle_busy1_r8", 64'(busy1), 64'd0);

        // Single primary write, then idle.
        chk_reg2 = 5'd9;
        prim(5'd9, 32'h2);
        tick();
        check("p9_we", 64'(we), 64'd1);
        check("p9_wreg", 64'(wreg), 64'd9);
        check("p9_wdata", 64'(wdata), 64'd2);
        check("p9_busy2", 64'(busy2), 64'd1);
        idle();
        tick();
        check("p9_idle_we", 64'(we), 64'd0);
        check("p9_idle_wreg_hold", 64'(wreg), 64'd9);
        check("p9_idle_busy2", 64'(busy2), 64'd0);

        // Queued r10 is overtaken by primary r11.
        chk_reg1 = 5'd10;
        mpush(5'd10, 32'hA);
        tick();
        check("m10_count", 64'(count), 64'd1);
        check("m10_we", 64'(we), 64'd0);
        check("m10_busy1", 64'(busy1), 64'd1);
        idle();
        prim(5'd11, 32'hB);
        tick();
        check("p11_wreg", 64'(wreg), 64'd11);
        check("p11_wdata", 64'(wdata), 64'hB);
        check("p11_count", 64'(count), 64'd1);
        check("p11_busy1_r10", 64'(busy1), 64'd1);
        idle();
        tick();
        check("pop10_we", 64'(we), 64'd1);
        check("pop10_wreg", 64'(wreg), 64'd10);
        check("pop10_wdata", 64'(wdata), 64'hA);
        check("pop10_count", 64'(count), 64'd0);
        check("pop10_busy1", 64'(busy1), 64'd1);
        tick();
        check("ret10_we", 64'(we), 64'd0);
        check("ret10_busy1", 64'(busy1), 64'd0);

        // Fill under continuous primary traffic, then drain in order.
        chk_reg1 = 5'd3;
        for (int i = 1; i <= 4; i++) begin
            prim(5'd20, 32'h200 + 32'(i));
            mpush(5'(i), 32'h100 + 32'(i));
            tick();
            check("fill_we", 64'(we), 64'd1);
            check("fill_wreg", 64'(wreg), 64'd20);
        end
        check("full_count", 64'(count), 64'd4);
        check("full_m_ready", 64'(m_ready), 64'd0);
        check("full_busy1_r3", 64'(busy1), 64'd1);
        mpush(5'd5, 32'h105);
        tick();
        check("full_reject_count", 64'(count), 64'd4);
        idle();
        tick();
        check("drain1_wreg", 64'(wreg), 64'd1);
        check("drain1_wdata", 64'(wdata), 64'h101);
        check("drain1_count", 64'(count), 64'd3);
        check("drain1_m_ready", 64'(m_ready), 64'd1);
        for (int i = 2; i <= 4; i++) begin
            tick();
            check("drain_we", 64'(we), 64'd1);
            check("drain_wreg", 64'(wreg), 64'(i));
            check("drain_wdata", 64'(wdata), 64'h100 + 64'(i));
        end
        check("drained_count", 64'(count), 64'd0);
        check("drained_busy1_r3", 64'(busy1), 64'd0);
        tick();
        check("drained_we", 64'(we), 64'd0);

        // Later primary to r12 squashes the queued r12.
        chk_reg1 = 5'd12;
        mpush(5'd12, 32'h1);
        tick();
        check("m12_count", 64'(count), 64'd1);
        idle();
        prim(5'd12, 32'h2);
        tick();
        check("p12_we", 64'(we), 64'd1);
        check("p12_wdata", 64'(wdata), 64'h2);
        check("p12_count", 64'(count), 64'd1);
        check("p12_busy1", 64'(busy1), 64'd1);
        idle();
        tick();
        check("sq12_we", 64'(we), 64'd0);
        check("sq12_count", 64'(count), 64'd0);
        check("sq12_busy1", 64'(busy1), 64'd0);

        // Same-cycle push and primary to r13: entry stored already squashed.
        chk_reg1 = 5'd13;
        prim(5'd13, 32'h33);
        mpush(5'd13, 32'h44);
        tick();
        check("p13_wdata", 64'(wdata), 64'h33);
        check("p13_count", 64'(count), 64'd1);
        idle();
        tick();
        check("sq13_we", 64'(we), 64'd0);
        check("sq13_busy1", 64'(busy1), 64'd0);
        check("sq13_count", 64'(count), 64'd0);

        // Simultaneous push and pop keeps count.
        mpush(5'd14, 32'hE);
        tick();
        mpush(5'd15, 32'hF);
        tick();
        check("pp_count", 64'(count), 64'd1);
        check("pp_wreg", 64'(wreg), 64'd14);
        idle();
        tick();
        check("pp2_wreg", 64'(wreg), 64'd15);
        check("pp2_wdata", 64'(wdata), 64'hF);
        check("pp2_count", 64'(count), 64'd0);

        // Writes to r0 from either source leave no trace.
        prim(5'd0, 32'hFFFF);
        mpush(5'd0, 32'hFFFF);
        tick();
        check("r0_we", 64'(we), 64'd0);
        check("r0_count", 64'(count), 64'd0);
        idle();
        tick();
        check("r0_we2", 64'(we), 64'd0);

        // Asynchronous reset with entries queued.
        prim(5'd20, 32'h7);
        mpush(5'd1, 32'h1);
        tick();
        mpush(5'd2, 32'h2);
        tick();
        check("prerst_count", 64'(count), 64'd2);
        check("prerst_we", 64'(we), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_count", 64'(count), 64'd0);
        check("midrst_we", 64'(we), 64'd0);
        check("midrst_m_ready", 64'(m_ready), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_queue.md
# wb_queue

Writeback buffer in front of the register file's single write port. Merges results from the main pipeline (always accepted, highest priority) and the multi-cycle multiply/divide unit (valid/ready handshake, buffered in a small FIFO). Drives the register file's registered write-enable, write-register and write-data inputs. Exports per-register pending-write flags that decode uses for hazard stalls.

## Interface
- DEPTH, 4: secondary FIFO entries (power of two, ≥2)
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous assert, active-low
- p_valid  in  1  main-pipeline write request; never back-pressured
- p_wreg  in  5  destination register
- p_wdata  in  32  write value
- m_valid  in  1  multi-cycle unit result valid
- m_ready  out  1  FIFO can accept; 0 while rst_n low
- m_wreg  in  5  destination register
- m_wdata  in  32  write value
- we  out  1  register-file write enable, registered
- wreg  out  5  register-file write register, registered
- wdata  out  32  register-file write data, registered
- chk_reg1, chk_reg2  in  5  registers queried by decode
- busy1, busy2  out  1  queried register has an unretired write
- count  out  $clog2(DEPTH)+1  valid FIFO occupancy

## Operation
- Reset values: FIFO empty, count=0, we=0, wreg=0, wdata=0, busy1=busy2=0.
- m_ready = (count < DEPTH). Push occurs when m_valid && m_ready.
- A push with m_wreg==0 is accepted but not stored.
- A primary request with p_wreg==0 is ignored, and the output stage loads we=0.
- Output stage selection, evaluated each cycle:
  - If p_valid and p_wreg≠0: load we=1, wreg=p_wreg, wdata=p_wdata.
  - Else if FIFO is non-empty: pop the head. Load we=head.live with the head's wreg/wdata.
  - Else: load we=0 and hold wreg/wdata.
- Squash rule: an accepted primary write to register r clears `live` on every FIFO entry with wreg==r, including an entry pushed in the same cycle.
  - Squashed entries still occupy a slot.
  - Squashed entries pop normally, but with we=0.
- The FIFO is strictly in order. The head never bypasses the primary.
- busy_k = (chk_reg_k≠0) && (any live FIFO entry has wreg==chk_reg_k, or (we && wreg==chk_reg_k)). busy_k is combinational from state and chk_reg_k only.
- count covers stored entries, whether live or squashed.

## Timing
- Primary request at cycle N → we/wreg/wdata valid from the edge ending N. The register file commits at the edge ending N+1.
- Secondary push at N, with no primary at N+1 → output loads at the edge ending N+1 (2-cycle latency).
- A push and a pop in the same cycle are both allowed, with count unchanged.
- When full, m_ready=0 even if a pop occurs that cycle. No combinational ready path.
- Continuous primary traffic starves the FIFO. The multi-cycle unit sees m_ready=0 once DEPTH results are queued.
- Pointers wrap modulo DEPTH. Full/empty is decided by count, not by pointer equality.
- Reset mid-operation: all queued entries are discarded, we drops to 0 asynchronously, and m_ready drops to 0 immediately.

## Structure
- Shared package `wb_pkg`:
  - REG_W=5, DATA_W=32
  - typedef wb_req_t {logic live; logic [REG_W-1:0] wreg; logic [DATA_W-1:0] wdata;}
- Sub-module `wb_fifo`: circular buffer of wb_req_t.
  - Owns pointers and count.
  - Exposes its entry array for squash and busy matching.
  - Accepts a squash_en/squash_reg input.
- Top level holds the output stage, arbitration and busy comparators.

## Test plan
- Reset release, idle → we=0, m_ready=1, count=0. Query r8 → busy1=0.
- p_valid, r9=0x0000_0002 at cycle N → we=1, wreg=9, wdata=2 after the edge ending N. Next cycle idle → we=0.
- Push m r10=0xA; at the next cycle p_valid r11=0xB → output shows r11 first, then r10. busy1(r10)=1 until r10 leaves the output stage.
- Push 4 m results while p_valid is held high → count=4, m_ready=0, a 5th m_valid is not accepted. Drop p_valid → four pops in order, m_ready returns to 1 the cycle after the first pop.
- Push m r12=0x1, then p_valid r12=0x2 → r12 written with 2. The queued entry later pops with we=0, and busy(r12) clears after the primary retires.
- m r0=0xFFFF pushed and p_valid r0 → no we=1 cycle. count stays 0. Assert rst_n low mid-queue → count=0 and we=0 immediately.
